// File: rtl/if_stage_if.sv
// Instruction-memory request/response bus between the fetch stage and the I-side memory.
// One request per ice strobe; exactly one inst_rvalid answers each request.
interface if_stage_if;
    logic        ice;
    logic [31:0] iaddr;
    logic [31:0] inst_rdata;
    logic        inst_rvalid;

    modport master (
        output ice,
        output iaddr,
        input  inst_rdata,
        input  inst_rvalid
    );

    modport slave (
        input  ice,
        input  iaddr,
        output inst_rdata,
        output inst_rvalid
    );
endinterface

// File: rtl/if_stage.sv
// MIPS32 instruction-fetch stage and IF/ID pipeline register.
// Keeps a single instruction-memory request in flight, delivers fetched words into IF/ID,
// follows branch/jump decisions from decode (including the delay slot) and handles
// decode stalls and exception flushes.
module if_stage #(
    parameter logic [31:0] PC_RESET = 32'hBFC0_0000
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        stall_id,
    input  logic        flush,
    input  logic [31:0] cp0_excaddr,
    input  logic [1:0]  jtsel,
    input  logic [31:0] jump_addr_1,
    input  logic [31:0] jump_addr_2,
    input  logic [31:0] jump_addr_3,
    input  logic        next_delay_i,
    if_stage_if.master  imem,
    output logic [31:0] id_pc_o,
    output logic [31:0] id_inst_o,
    output logic [31:0] id_pc_plus_4_o,
    output logic        id_in_delay_o
);

    // StDrop waits for, and throws away, the response to a request killed by a flush.
    typedef enum logic [2:0] {
        StIdle,
        StReq,
        StWait,
        StHold,
        StDrop
    } state_e;

    state_e      state_q, state_d;
    logic [31:0] pc_q, pc_d;
    logic        ice_q, ice_d;
    logic [31:0] skid_q, skid_d;
    logic        redir_v_q, redir_v_d;
    logic [31:0] redir_pc_q, redir_pc_d;
    logic        pend_delay_q, pend_delay_d;
    logic [31:0] id_pc_q, id_pc_d;
    logic [31:0] id_inst_q, id_inst_d;
    logic [31:0] id_pc4_q, id_pc4_d;
    logic        id_delay_q, id_delay_d;

    logic [31:0] pc_plus_4;
    logic        jump_v;
    logic [31:0] jump_target;
    logic        deliver;
    logic [31:0] deliver_word;
    logic [31:0] next_pc;

    assign pc_plus_4 = pc_q + 32'd4;
    assign jump_v    = (jtsel != 2'b00);

    // Redirect target chosen by decode for the instruction currently in ID.
    always_comb begin
        jump_target = pc_plus_4;
        unique case (jtsel)
            2'b00: jump_target = pc_plus_4;
            2'b01: jump_target = jump_addr_1;
            2'b10: jump_target = jump_addr_3;
            2'b11: jump_target = jump_addr_2;
        endcase
    end

    // A word moves into IF/ID either straight from memory or from the skid buffer.
    assign deliver = !flush && !stall_id &&
                     (((state_q == StWait) && imem.inst_rvalid) || (state_q == StHold));
    assign deliver_word = (state_q == StHold) ? skid_q : imem.inst_rdata;

    // A live decision beats a latched one; the latch only matters once the branch left ID.
    assign next_pc = jump_v    ? jump_target :
                     redir_v_q ? redir_pc_q  :
                                 pc_plus_4;

    // Next-state for the fetch FSM, PC, decision latch and IF/ID register.
    always_comb begin
        state_d      = state_q;
        pc_d         = pc_q;
        skid_d       = skid_q;
        redir_v_d    = redir_v_q;
        redir_pc_d   = redir_pc_q;
        pend_delay_d = pend_delay_q;
        id_pc_d      = id_pc_q;
        id_inst_d    = id_inst_q;
        id_pc4_d     = id_pc4_q;
        id_delay_d   = id_delay_q;

        unique case (state_q)
            StIdle: state_d = StReq;
            StReq:  state_d = StWait;
            StWait: begin
                if (imem.inst_rvalid) begin
                    if (stall_id) begin
                        skid_d  = imem.inst_rdata;
                        state_d = StHold;
                    end else begin
                        state_d = StReq;
                    end
                end
            end
            StHold: begin
                if (!stall_id) begin
                    state_d = StReq;
                end
            end
            StDrop: begin
                if (imem.inst_rvalid) begin
                    state_d = StReq;
                end
            end
            default: state_d = StIdle;
        endcase

        if (deliver) begin
            id_pc_d      = pc_q;
            id_inst_d    = deliver_word;
            id_pc4_d     = pc_plus_4;
            id_delay_d   = next_delay_i | pend_delay_q;
            pc_d         = next_pc;
            redir_v_d    = 1'b0;
            pend_delay_d = 1'b0;
            skid_d       = '0;
        end else if (!stall_id) begin
            // ID is taking a bubble: remember any decision so the delay slot still honours it.
            id_pc_d    = '0;
            id_inst_d  = '0;
            id_pc4_d   = '0;
            id_delay_d = 1'b0;
            if (jump_v) begin
                redir_v_d  = 1'b1;
                redir_pc_d = jump_target;
            end
            if (next_delay_i) begin
                pend_delay_d = 1'b1;
            end
        end

        if (flush) begin
            pc_d         = cp0_excaddr;
            id_pc_d      = '0;
            id_inst_d    = '0;
            id_pc4_d     = '0;
            id_delay_d   = 1'b0;
            redir_v_d    = 1'b0;
            pend_delay_d = 1'b0;
            skid_d       = '0;
            // A request still in flight must have its response swallowed before refetching.
            unique case (state_q)
                StReq:   state_d = StDrop;
                StWait:  state_d = imem.inst_rvalid ? StReq : StDrop;
                StDrop:  state_d = imem.inst_rvalid ? StReq : StDrop;
                default: state_d = StReq;
            endcase
        end

        ice_d = (state_d == StReq);
    end

    // All stage state, with ice registered so the strobe has no input-to-output path.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q      <= StIdle;
            pc_q         <= PC_RESET;
            ice_q        <= 1'b0;
            skid_q       <= '0;
            redir_v_q    <= 1'b0;
            redir_pc_q   <= '0;
            pend_delay_q <= 1'b0;
            id_pc_q      <= '0;
            id_inst_q    <= '0;
            id_pc4_q     <= '0;
            id_delay_q   <= 1'b0;
        end else begin
            state_q      <= state_d;
            pc_q         <= pc_d;
            ice_q        <= ice_d;
            skid_q       <= skid_d;
            redir_v_q    <= redir_v_d;
            redir_pc_q   <= redir_pc_d;
            pend_delay_q <= pend_delay_d;
            id_pc_q      <= id_pc_d;
            id_inst_q    <= id_inst_d;
            id_pc4_q     <= id_pc4_d;
            id_delay_q   <= id_delay_d;
        end
    end

    assign imem.ice       = ice_q;
    assign imem.iaddr     = pc_q;
    assign id_pc_o        = id_pc_q;
    assign id_inst_o      = id_inst_q;
    assign id_pc_plus_4_o = id_pc4_q;
    assign id_in_delay_o  = id_delay_q;

endmodule

// File: tb/tb_if_stage.sv
// Bench for if_stage: directed scenarios plus a randomized sequential-fetch stream checked
// against a request/response scoreboard, with a variable-latency memory responder.
module tb_if_stage;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        stall_id = 1'b0;
    logic        flush = 1'b0;
    logic [31:0] cp0_excaddr = '0;
    logic [1:0]  jtsel = '0;
    logic [31:0] jump_addr_1 = '0;
    logic [31:0] jump_addr_2 = '0;
    logic [31:0] jump_addr_3 = '0;
    logic        next_delay_i = 1'b0;
    logic [31:0] id_pc_o;
    logic [31:0] id_inst_o;
    logic [31:0] id_pc_plus_4_o;
    logic        id_in_delay_o;

    int n_pass = 0;
    int n_total = 0;

    int unsigned mem_lat = 1;
    bit          mem_bad = 1'b0;

    if_stage_if bus ();

    if_stage #(
        .PC_RESET(32'hBFC0_0000)
    ) dut (
        .clk           (clk),
        .rst_n         (rst_n),
        .stall_id      (stall_id),
        .flush         (flush),
        .cp0_excaddr   (cp0_excaddr),
        .jtsel         (jtsel),
        .jump_addr_1   (jump_addr_1),
        .jump_addr_2   (jump_addr_2),
        .jump_addr_3   (jump_addr_3),
        .next_delay_i  (next_delay_i),
        .imem          (bus),
        .id_pc_o       (id_pc_o),
        .id_inst_o     (id_inst_o),
        .id_pc_plus_4_o(id_pc_plus_4_o),
        .id_in_delay_o (id_in_delay_o)
    );

    initial forever #5 clk = ~clk;

    // Memory contents: a fixed word at the reset vector, otherwise a nonzero address hash.
    function automatic logic [31:0] mem_word(input logic [31:0] a);
        if (a == 32'hBFC0_0000) return 32'h3C01_1234;
        return {a[15:0], ~a[15:0]};
    endfunction

    // Memory responder: a request seen on ice is answered mem_lat cycles after it is taken.
    initial begin : memory
        bit          pend_req;
        bit          busy;
        int unsigned cnt;
        logic [31:0] addr;
        logic [31:0] req_addr;
        pend_req = 1'b0;
        busy = 1'b0;
        cnt = 0;
        addr = '0;
        req_addr = '0;
        bus.inst_rvalid = 1'b0;
        bus.inst_rdata = '0;
        forever begin
            @(posedge clk);
            #1;
            bus.inst_rvalid = 1'b0;
            if (!rst_n) begin
                pend_req = 1'b0;
                busy = 1'b0;
            end else begin
                if (pend_req) begin
                    busy = 1'b1;
                    cnt = mem_lat;
                    addr = req_addr;
                    pend_req = 1'b0;
                end
                if (busy) begin
                    cnt--;
                    if (cnt == 0) begin
                        bus.inst_rvalid = 1'b1;
                        bus.inst_rdata = mem_bad ? 32'hDEAD_BEEF : mem_word(addr);
                        busy = 1'b0;
                    end
                end
                if (bus.ice === 1'b1) begin
                    pend_req = 1'b1;
                    req_addr = bus.iaddr;
                end
            end
        end
    end

    initial begin : watchdog
        #2_000_000;
        $display("FAIL watchdog: time limit reached, got %0d/%0d", n_pass, n_total);
        $fatal(1);
    end

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic drive_idle();
        stall_id = 1'b0;
        flush = 1'b0;
        cp0_excaddr = '0;
        jtsel = 2'b00;
        jump_addr_1 = '0;
        jump_addr_2 = '0;
        jump_addr_3 = '0;
        next_delay_i = 1'b0;
        mem_bad = 1'b0;
    endtask

    task automatic do_reset();
        drive_idle();
        rst_n = 1'b0;
        repeat (2) @(posedge clk);
        @(negedge clk);
        rst_n = 1'b1;
    endtask

    task automatic wait_delivery(input int max_cyc, output bit ok);
        ok = 1'b0;
        for (int i = 0; i < max_cyc; i++) begin
            step();
            if (id_inst_o !== 32'h0) begin
                ok = 1'b1;
                break;
            end
        end
    endtask

    task automatic wait_ice(input int max_cyc, output bit ok);
        ok = (bus.ice === 1'b1);
        for (int i = 0; i < max_cyc && !ok; i++) begin
            step();
            if (bus.ice === 1'b1) ok = 1'b1;
        end
    endtask

    task automatic test_reset();
        mem_lat = 1;
        drive_idle();
        rst_n = 1'b0;
        repeat (2) @(posedge clk);
        #1;
        n_total++;
        if ({bus.ice, id_pc_o, id_inst_o, id_pc_plus_4_o, id_in_delay_o} !== '0) begin
            $display("FAIL reset_outputs: got ice=%b pc=%h inst=%h pc4=%h dly=%b want all 0",
                     bus.ice, id_pc_o, id_inst_o, id_pc_plus_4_o, id_in_delay_o);
        end else n_pass++;
        n_total++;
        if (bus.iaddr !== 32'hBFC0_0000) begin
            $display("FAIL reset_pc: got %h want bfc00000", bus.iaddr);
        end else n_pass++;
        @(negedge clk);
        rst_n = 1'b1;
        #1;
        n_total++;
        if (bus.ice !== 1'b0) begin
            $display("FAIL first_cycle_ice: got %b want 0", bus.ice);
        end else n_pass++;
        step();
        n_total++;
        if (bus.ice !== 1'b1 || bus.iaddr !== 32'hBFC0_0000) begin
            $display("FAIL first_req: got ice=%b iaddr=%h want ice=1 iaddr=bfc00000",
                     bus.ice, bus.iaddr);
        end else n_pass++;
        step();
        n_total++;
        if (bus.ice !== 1'b0) begin
            $display("FAIL single_strobe: got ice=%b want 0", bus.ice);
        end else n_pass++;
        step();
        n_total++;
        if (id_inst_o !== 32'h3C01_1234 || id_pc_o !== 32'hBFC0_0000 ||
            id_pc_plus_4_o !== 32'hBFC0_0004 || id_in_delay_o !== 1'b0) begin
            $display("FAIL first_deliver: got pc=%h inst=%h pc4=%h dly=%b want bfc00000 3c011234 bfc00004 0",
                     id_pc_o, id_inst_o, id_pc_plus_4_o, id_in_delay_o);
        end else n_pass++;
        n_total++;
        if (bus.ice !== 1'b1 || bus.iaddr !== 32'hBFC0_0004) begin
            $display("FAIL second_req: got ice=%b iaddr=%h want ice=1 iaddr=bfc00004",
                     bus.ice, bus.iaddr);
        end else n_pass++;
    endtask

    task automatic test_branch_live();
        bit ok;
        mem_lat = 1;
        do_reset();
        wait_delivery(10, ok);
        wait_delivery(10, ok);
        n_total++;
        if (!ok || id_pc_o !== 32'hBFC0_0004) begin
            $display("FAIL live_branch_setup: got ok=%b pc=%h want 1 bfc00004", ok, id_pc_o);
        end else n_pass++;
        // beq taken; the other targets are decoys so a wrong selection shows up.
        jtsel = 2'b11;
        jump_addr_1 = 32'hBFC0_0AA0;
        jump_addr_2 = 32'hBFC0_0040;
        jump_addr_3 = 32'hBFC0_0BB0;
        next_delay_i = 1'b1;
        wait_delivery(10, ok);
        n_total++;
        if (!ok || id_pc_o !== 32'hBFC0_0008 || id_in_delay_o !== 1'b1 ||
            id_inst_o !== mem_word(32'hBFC0_0008)) begin
            $display("FAIL live_delay_slot: got ok=%b pc=%h dly=%b inst=%h want bfc00008 1 %h",
                     ok, id_pc_o, id_in_delay_o, id_inst_o, mem_word(32'hBFC0_0008));
        end else n_pass++;
        wait_ice(4, ok);
        n_total++;
        if (!ok || bus.iaddr !== 32'hBFC0_0040) begin
            $display("FAIL live_target: got ok=%b iaddr=%h want bfc00040", ok, bus.iaddr);
        end else n_pass++;
        jtsel = 2'b00;
        next_delay_i = 1'b0;
        wait_delivery(10, ok);
        n_total++;
        if (!ok || id_pc_o !== 32'hBFC0_0040 || id_in_delay_o !== 1'b0) begin
            $display("FAIL live_after_target: got pc=%h dly=%b want bfc00040 0",
                     id_pc_o, id_in_delay_o);
        end else n_pass++;
        // jr from BFC00040.
        jtsel = 2'b10;
        jump_addr_3 = 32'hBFC0_0200;
        next_delay_i = 1'b1;
        wait_delivery(10, ok);
        n_total++;
        if (!ok || id_pc_o !== 32'hBFC0_0044 || id_in_delay_o !== 1'b1) begin
            $display("FAIL jr_delay_slot: got pc=%h dly=%b want bfc00044 1", id_pc_o, id_in_delay_o);
        end else n_pass++;
        wait_ice(4, ok);
        n_total++;
        if (!ok || bus.iaddr !== 32'hBFC0_0200) begin
            $display("FAIL jr_target: got ok=%b iaddr=%h want bfc00200", ok, bus.iaddr);
        end else n_pass++;
        drive_idle();
    endtask

    task automatic test_jump_latched();
        bit ok;
        mem_lat = 3;
        do_reset();
        wait_delivery(20, ok);
        wait_delivery(20, ok);
        n_total++;
        if (!ok || id_pc_o !== 32'hBFC0_0004) begin
            $display("FAIL latch_setup: got ok=%b pc=%h want 1 bfc00004", ok, id_pc_o);
        end else n_pass++;
        // j seen for exactly one cycle, then the jump leaves ID as a bubble.
        jtsel = 2'b01;
        jump_addr_1 = 32'hBFC0_0100;
        jump_addr_2 = 32'hBFC0_0CC0;
        jump_addr_3 = 32'hBFC0_0DD0;
        next_delay_i = 1'b1;
        step();
        jtsel = 2'b00;
        next_delay_i = 1'b0;
        n_total++;
        if (id_inst_o !== 32'h0 || id_pc_o !== 32'h0 || id_in_delay_o !== 1'b0) begin
            $display("FAIL latch_bubble: got inst=%h pc=%h dly=%b want 0 0 0",
                     id_inst_o, id_pc_o, id_in_delay_o);
        end else n_pass++;
        wait_delivery(20, ok);
        n_total++;
        if (!ok || id_pc_o !== 32'hBFC0_0008 || id_in_delay_o !== 1'b1) begin
            $display("FAIL latch_delay_slot: got ok=%b pc=%h dly=%b want 1 bfc00008 1",
                     ok, id_pc_o, id_in_delay_o);
        end else n_pass++;
        wait_ice(4, ok);
        n_total++;
        if (!ok || bus.iaddr !== 32'hBFC0_0100) begin
            $display("FAIL latch_target: got ok=%b iaddr=%h want bfc00100", ok, bus.iaddr);
        end else n_pass++;
        wait_delivery(20, ok);
        n_total++;
        if (!ok || id_pc_o !== 32'hBFC0_0100 || id_in_delay_o !== 1'b0 ||
            id_inst_o !== mem_word(32'hBFC0_0100)) begin
            $display("FAIL latch_after_target: got pc=%h dly=%b inst=%h want bfc00100 0 %h",
                     id_pc_o, id_in_delay_o, id_inst_o, mem_word(32'hBFC0_0100));
        end else n_pass++;
        drive_idle();
    endtask

    task automatic test_stall_pending();
        bit          ok;
        logic [31:0] snap_pc;
        logic [31:0] snap_inst;
        mem_lat = 1;
        do_reset();
        wait_delivery(10, ok);
        step();
        stall_id = 1'b1;
        snap_pc = id_pc_o;
        snap_inst = id_inst_o;
        for (int i = 0; i < 3; i++) begin
            step();
            n_total++;
            if (id_pc_o !== snap_pc || id_inst_o !== snap_inst || bus.ice !== 1'b0) begin
                $display("FAIL stall_hold[%0d]: got pc=%h inst=%h ice=%b want %h %h 0",
                         i, id_pc_o, id_inst_o, bus.ice, snap_pc, snap_inst);
            end else n_pass++;
        end
        stall_id = 1'b0;
        step();
        n_total++;
        if (id_pc_o !== 32'hBFC0_0004 || id_inst_o !== mem_word(32'hBFC0_0004)) begin
            $display("FAIL stall_release: got pc=%h inst=%h want bfc00004 %h",
                     id_pc_o, id_inst_o, mem_word(32'hBFC0_0004));
        end else n_pass++;
        n_total++;
        if (bus.ice !== 1'b1 || bus.iaddr !== 32'hBFC0_0008) begin
            $display("FAIL stall_next_req: got ice=%b iaddr=%h want 1 bfc00008",
                     bus.ice, bus.iaddr);
        end else n_pass++;
        wait_delivery(10, ok);
        n_total++;
        if (!ok || id_pc_o !== 32'hBFC0_0008) begin
            $display("FAIL stall_no_dup: got ok=%b pc=%h want 1 bfc00008", ok, id_pc_o);
        end else n_pass++;
    endtask

    task automatic test_flush_wait();
        bit ok;
        bit got;
        mem_lat = 3;
        do_reset();
        wait_delivery(20, ok);
        step();
        flush = 1'b1;
        cp0_excaddr = 32'hBFC0_0380;
        mem_bad = 1'b1;
        step();
        flush = 1'b0;
        n_total++;
        if (id_inst_o !== 32'h0 || id_pc_o !== 32'h0) begin
            $display("FAIL flush_bubble: got inst=%h pc=%h want 0 0", id_inst_o, id_pc_o);
        end else n_pass++;
        got = 1'b0;
        for (int i = 0; i < 8; i++) begin
            if (bus.ice === 1'b1) begin
                got = 1'b1;
                break;
            end
            step();
            n_total++;
            if (id_inst_o !== 32'h0) begin
                $display("FAIL flush_drop[%0d]: got inst=%h want 0", i, id_inst_o);
            end else n_pass++;
        end
        n_total++;
        if (!got || bus.iaddr !== 32'hBFC0_0380) begin
            $display("FAIL flush_refetch: got ice_seen=%b iaddr=%h want 1 bfc00380",
                     got, bus.iaddr);
        end else n_pass++;
        mem_bad = 1'b0;
        wait_delivery(20, ok);
        n_total++;
        if (!ok || id_pc_o !== 32'hBFC0_0380 || id_inst_o !== mem_word(32'hBFC0_0380)) begin
            $display("FAIL flush_deliver: got pc=%h inst=%h want bfc00380 %h",
                     id_pc_o, id_inst_o, mem_word(32'hBFC0_0380));
        end else n_pass++;
        drive_idle();
    endtask

    task automatic test_async_reset();
        bit ok;
        mem_lat = 1;
        do_reset();
        wait_delivery(10, ok);
        step();
        stall_id = 1'b1;
        step();
        step();
        #2;
        rst_n = 1'b0;
        #1;
        n_total++;
        if ({bus.ice, id_pc_o, id_inst_o, id_pc_plus_4_o, id_in_delay_o} !== '0 ||
            bus.iaddr !== 32'hBFC0_0000) begin
            $display("FAIL async_reset: got ice=%b iaddr=%h pc=%h inst=%h want 0 bfc00000 0 0",
                     bus.ice, bus.iaddr, id_pc_o, id_inst_o);
        end else n_pass++;
        stall_id = 1'b0;
        @(negedge clk);
        rst_n = 1'b1;
        step();
        n_total++;
        if (bus.ice !== 1'b1 || bus.iaddr !== 32'hBFC0_0000) begin
            $display("FAIL async_restart_req: got ice=%b iaddr=%h want 1 bfc00000",
                     bus.ice, bus.iaddr);
        end else n_pass++;
        step();
        step();
        n_total++;
        if (id_inst_o !== 32'h3C01_1234 || id_pc_o !== 32'hBFC0_0000) begin
            $display("FAIL async_restart_deliver: got pc=%h inst=%h want bfc00000 3c011234",
                     id_pc_o, id_inst_o);
        end else n_pass++;
    endtask

    // Sequential fetch under random latency and random stalls: every delivered word must be
    // the oldest outstanding request, addresses must step by 4, and a stall freezes IF/ID.
    task automatic test_random_stream();
        logic [31:0] req_q[$];
        logic [31:0] exp_req;
        logic [31:0] exp_pc;
        logic [31:0] s_pc;
        logic [31:0] s_inst;
        logic [31:0] s_pc4;
        logic        s_dly;
        bit          st_prev;
        int          n_del;
        for (int run = 0; run < 3; run++) begin
            mem_lat = $urandom_range(4, 1);
            do_reset();
            req_q.delete();
            exp_req = 32'hBFC0_0000;
            st_prev = 1'b0;
            n_del = 0;
            s_pc = '0;
            s_inst = '0;
            s_pc4 = '0;
            s_dly = 1'b0;
            for (int cyc = 0; cyc < 150; cyc++) begin
                step();
                n_total++;
                if (st_prev) begin
                    if ({id_pc_o, id_inst_o, id_pc_plus_4_o, id_in_delay_o} !==
                        {s_pc, s_inst, s_pc4, s_dly}) begin
                        $display("FAIL rand_stall_hold: got pc=%h inst=%h want %h %h",
                                 id_pc_o, id_inst_o, s_pc, s_inst);
                    end else n_pass++;
                end else if (id_inst_o !== 32'h0) begin
                    n_del++;
                    if (req_q.size() == 0) begin
                        $display("FAIL rand_unrequested: got pc=%h with no request outstanding",
                                 id_pc_o);
                    end else begin
                        exp_pc = req_q.pop_front();
                        if (id_pc_o !== exp_pc || id_inst_o !== mem_word(exp_pc) ||
                            id_pc_plus_4_o !== exp_pc + 32'd4 || id_in_delay_o !== 1'b0) begin
                            $display("FAIL rand_deliver: got pc=%h inst=%h pc4=%h dly=%b want %h %h %h 0",
                                     id_pc_o, id_inst_o, id_pc_plus_4_o, id_in_delay_o,
                                     exp_pc, mem_word(exp_pc), exp_pc + 32'd4);
                        end else n_pass++;
                    end
                end else begin
                    if (id_pc_o !== 32'h0 || id_in_delay_o !== 1'b0) begin
                        $display("FAIL rand_bubble: got pc=%h dly=%b want 0 0",
                                 id_pc_o, id_in_delay_o);
                    end else n_pass++;
                end
                if (bus.ice === 1'b1) begin
                    n_total++;
                    if (req_q.size() != 0 || bus.iaddr !== exp_req) begin
                        $display("FAIL rand_request: got iaddr=%h outstanding=%0d want %h 0",
                                 bus.iaddr, req_q.size(), exp_req);
                    end else n_pass++;
                    req_q.push_back(exp_req);
                    exp_req = exp_req + 32'd4;
                end
                s_pc = id_pc_o;
                s_inst = id_inst_o;
                s_pc4 = id_pc_plus_4_o;
                s_dly = id_in_delay_o;
                stall_id = ($urandom_range(99) < 35);
                st_prev = stall_id;
            end
            stall_id = 1'b0;
            n_total++;
            if (n_del < 10) begin
                $display("FAIL rand_progress: got %0d deliveries want at least 10", n_del);
            end else n_pass++;
        end
    endtask

    initial begin
        test_reset();
        test_branch_live();
        test_jump_latched();
        test_stall_pending();
        test_flush_wait();
        test_async_reset();
        test_random_stream();
        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule
